// File: rtl/ema_pkg.sv
// Shared types, default timing and sizing helpers for the EMA burst excitation source.
package ema_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_P_ON    = 3'd1,
        ST_DEAD_PN = 3'd2,
        ST_N_ON    = 3'd3,
        ST_DEAD_NP = 3'd4
    } ema_state_e;

    localparam int CLK_HZ          = 20_000_000;
    localparam int DEF_HALF_PERIOD = 10;     // 1 MHz excitation at CLK_HZ
    localparam int DEF_DEAD_TIME   = 2;
    localparam int DEF_NUM_PERIODS = 4;
    localparam int DEF_REP_PERIOD  = 20_000; // 1 kHz burst repetition at CLK_HZ

    // Bits needed for a counter running 0..bound-1, never less than one bit.
    function automatic int cnt_width(input int bound);
        return (bound <= 2) ? 1 : $clog2(bound);
    endfunction

endpackage

// File: rtl/ema_trig_sync.sv
// Two-flop synchronizer for an asynchronous board input, followed by a registered
// rising-edge detector that emits a single-cycle pulse.
module ema_trig_sync (
    input  logic clk_i,
    input  logic rst_i,
    input  logic async_i,
    output logic rise_o
);

    logic meta_q;
    logic sync_q;
    logic prev_q;
    logic rise_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
            rise_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep each stage one clock behind the previous one.
            meta_q <= async_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
            rise_q <= sync_q & ~prev_q;
        end
    end

    assign rise_o = rise_q;

endmodule

// File: rtl/ema_burst_gen.sv
// Burst excitation source for the EMA H-bridge: NUM_PERIODS complementary periods with
// dead time, started by an internal repetition timer or a synchronized external trigger.
module ema_burst_gen
    import ema_pkg::*;
#(
    parameter int HALF_PERIOD = DEF_HALF_PERIOD,
    parameter int DEAD_TIME   = DEF_DEAD_TIME,
    parameter int NUM_PERIODS = DEF_NUM_PERIODS,
    parameter int REP_PERIOD  = DEF_REP_PERIOD
) (
    input  logic CLK_0,
    input  logic RST,
    input  logic ENABLE,
    input  logic EXT_MODE,
    input  logic TRIG,
    output logic EMA_PULSE_P,
    output logic EMA_PULSE_N,
    output logic BUSY,
    output logic BURST_DONE,
    output logic TRIG_MISS
);

    localparam int ON_CYCLES = HALF_PERIOD - DEAD_TIME;
    localparam int PH_W      = cnt_width(HALF_PERIOD);
    localparam int PER_W     = cnt_width(NUM_PERIODS);
    localparam int REP_W     = cnt_width(REP_PERIOD);

    localparam logic [PH_W-1:0]  ON_LAST   = PH_W'(ON_CYCLES - 1);
    localparam logic [PH_W-1:0]  DEAD_LAST = PH_W'(DEAD_TIME - 1);
    localparam logic [PER_W-1:0] PER_LAST  = PER_W'(NUM_PERIODS - 1);
    localparam logic [REP_W-1:0] REP_LAST  = REP_W'(REP_PERIOD - 1);

    generate
        if (DEAD_TIME < 1 || DEAD_TIME >= HALF_PERIOD || NUM_PERIODS < 1 ||
            REP_PERIOD <= 2 * HALF_PERIOD * NUM_PERIODS) begin : g_bad_params
            $error("ema_burst_gen: illegal HALF_PERIOD/DEAD_TIME/NUM_PERIODS/REP_PERIOD");
        end
    endgenerate

    logic trig_rise;

    ema_trig_sync u_trig_sync (
        .clk_i   (CLK_0),
        .rst_i   (RST),
        .async_i (TRIG),
        .rise_o  (trig_rise)
    );

    ema_state_e       state_q, state_d;
    logic [PH_W-1:0]  phase_q, phase_d;
    logic [PER_W-1:0] period_q, period_d;
    logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;
    logic             done_d;
    logic             start_req;
    logic             pulse_p_q, pulse_n_q, busy_q, done_q, miss_q;

    // Repetition timer only free-runs in internal mode with the block enabled.
    always_comb begin
        rep_cnt_d = rep_cnt_q + 1'b1;
        if (!ENABLE || EXT_MODE || rep_cnt_q == REP_LAST) begin
            rep_cnt_d = '0;
        end
    end

    assign start_req = ENABLE && (EXT_MODE ? trig_rise : (rep_cnt_q == REP_LAST));

    always_comb begin
        // NOTE: every always_comb output gets a default first, so no latch can be inferred.
        state_d  = state_q;
        phase_d  = phase_q + 1'b1;
        period_d = period_q;
        done_d   = 1'b0;
        if (state_q != ST_IDLE && !ENABLE) begin
            state_d  = ST_IDLE;
            phase_d  = '0;
            period_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    phase_d = '0;
                    if (start_req) begin
                        state_d = ST_P_ON;
                    end
                end
                ST_P_ON: begin
                    if (phase_q == ON_LAST) begin
                        state_d = ST_DEAD_PN;
                        phase_d = '0;
                    end
                end
                ST_DEAD_PN: begin
                    if (phase_q == DEAD_LAST) begin
                        state_d = ST_N_ON;
                        phase_d = '0;
                    end
                end
                ST_N_ON: begin
                    if (phase_q == ON_LAST) begin
                        state_d = ST_DEAD_NP;
                        phase_d = '0;
                    end
                end
                ST_DEAD_NP: begin
                    if (phase_q == DEAD_LAST) begin
                        phase_d = '0;
                        if (period_q == PER_LAST) begin
                            state_d  = ST_IDLE;
                            period_d = '0;
                            done_d   = 1'b1;
                        end else begin
                            state_d  = ST_P_ON;
                            period_d = period_q + 1'b1;
                        end
                    end
                end
                default: begin
                    state_d  = ST_IDLE;
                    phase_d  = '0;
                    period_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge CLK_0 or posedge RST) begin
        if (RST) begin
            state_q   <= ST_IDLE;
            phase_q   <= '0;
            period_q  <= '0;
            rep_cnt_q <= '0;
            pulse_p_q <= 1'b0;
            pulse_n_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            miss_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            period_q  <= period_d;
            rep_cnt_q <= rep_cnt_d;
            // Legs decode the next state, so they switch on the same edge as the state and
            // can never both be high.
            pulse_p_q <= (state_d == ST_P_ON);
            pulse_n_q <= (state_d == ST_N_ON);
            busy_q    <= (state_d != ST_IDLE);
            done_q    <= done_d;
            miss_q    <= start_req && (state_q != ST_IDLE);
        end
    end

    assign EMA_PULSE_P = pulse_p_q;
    assign EMA_PULSE_N = pulse_n_q;
    assign BUSY        = busy_q;
    assign BURST_DONE  = done_q;
    assign TRIG_MISS   = miss_q;

endmodule

// File: tb/tb_ema_burst_gen.sv
// Self-checking bench for ema_burst_gen: behavioural burst model plus directed corner cases.
`timescale 1ns/1ps
module tb_ema_burst_gen;

    localparam int H = 10;
    localparam int D = 2;
    localparam int NP = 4;
    localparam int R = 20000;
    localparam int L = 2 * H * NP;

    logic clk = 1'b0;
    logic rst, en, ext, trig;
    logic p, n, busy, done, miss;
    logic s_en, s_ext, s_trig;
    logic s_p, s_n, s_busy, s_done, s_miss;

    always #25 clk = ~clk;

    ema_burst_gen dut (
        .CLK_0(clk), .RST(rst), .ENABLE(en), .EXT_MODE(ext), .TRIG(trig),
        .EMA_PULSE_P(p), .EMA_PULSE_N(n), .BUSY(busy), .BURST_DONE(done), .TRIG_MISS(miss)
    );

    ema_burst_gen #(.HALF_PERIOD(3), .DEAD_TIME(1), .NUM_PERIODS(1), .REP_PERIOD(20)) dut_s (
        .CLK_0(clk), .RST(rst), .ENABLE(s_en), .EXT_MODE(s_ext), .TRIG(s_trig),
        .EMA_PULSE_P(s_p), .EMA_PULSE_N(s_n), .BUSY(s_busy), .BURST_DONE(s_done), .TRIG_MISS(s_miss)
    );

    int n_total = 0;
    int n_pass  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Legs of either instance must never be high together.
    always @(negedge clk) begin
        check("p_and_n_exclusive", 32'(p & n | s_p & s_n), 32'd0);
    end

    // Behavioural model state: burst start edge, enabled-run length, TRIG sample history.
    int  cyc = 0;
    bit  m_active = 1'b0;
    int  m_start = 0;
    int  m_run = 0;
    bit  m_th [1:4];
    int  busy_cnt, done_cnt, miss_cnt;
    int  b_rises [$];
    logic last_busy = 1'b0;

    task automatic model_reset();
        m_active = 1'b0;
        m_run = 0;
        for (int i = 1; i <= 4; i++) m_th[i] = 1'b0;
    endtask

    task automatic clear_stats();
        busy_cnt = 0;
        done_cnt = 0;
        miss_cnt = 0;
        b_rises.delete();
    endtask

    function automatic int qat(input int i);
        return (b_rises.size() > i) ? b_rises[i] : -1;
    endfunction

    task automatic tick();
        bit v_trig, v_en, v_ext, req, prev, done_e, miss_e;
        int k, pos;
        logic [4:0] exp_v;
        v_trig = trig;
        v_en   = en;
        v_ext  = ext;
        @(posedge clk);
        #1;
        cyc++;
        req = 1'b0;
        if (v_en) req = v_ext ? (m_th[3] && !m_th[4]) : ((m_run % R) == R - 1);
        m_run = (v_en && !v_ext) ? m_run + 1 : 0;
        m_th[4] = m_th[3];
        m_th[3] = m_th[2];
        m_th[2] = m_th[1];
        m_th[1] = v_trig;
        prev = m_active;
        done_e = 1'b0;
        if (m_active && !v_en) begin
            m_active = 1'b0;
        end else if (m_active && cyc == m_start + L) begin
            m_active = 1'b0;
            done_e = 1'b1;
        end
        miss_e = req && prev;
        if (req && !prev) begin
            m_active = 1'b1;
            m_start = cyc;
        end
        exp_v = '0;
        if (m_active) begin
            k = cyc - m_start;
            pos = k % (2 * H);
            exp_v[4] = (pos < H - D);
            exp_v[3] = (pos >= H) && (pos < 2 * H - D);
            exp_v[2] = 1'b1;
        end
        exp_v[1] = done_e;
        exp_v[0] = miss_e;
        check($sformatf("outputs@%0d", cyc), 32'({p, n, busy, done, miss}), 32'(exp_v));
        busy_cnt += int'(busy);
        done_cnt += int'(done);
        miss_cnt += int'(miss);
        if (busy && !last_busy) b_rises.push_back(cyc);
        last_busy = busy;
    endtask

    typedef struct {
        logic       trig;
        logic [4:0] exp;   // {P, N, BUSY, BURST_DONE, TRIG_MISS}
    } vec_t;

    vec_t tbl [23];
    int   te, t0, s;

    initial begin
        for (int i = 0; i < 23; i++) begin
            tbl[i].trig = (i <= 2 || i == 12 || i == 14);
            tbl[i].exp  = 5'b00000;
        end
        tbl[3].exp  = 5'b10100;  tbl[4].exp  = 5'b10100;  tbl[5].exp  = 5'b00100;
        tbl[6].exp  = 5'b01100;  tbl[7].exp  = 5'b01100;  tbl[8].exp  = 5'b00100;
        tbl[9].exp  = 5'b00010;
        tbl[15].exp = 5'b10100;  tbl[16].exp = 5'b10100;  tbl[17].exp = 5'b00101;
        tbl[18].exp = 5'b01100;  tbl[19].exp = 5'b01100;  tbl[20].exp = 5'b00100;
        tbl[21].exp = 5'b00010;

        rst = 1'b1; en = 1'b0; ext = 1'b1; trig = 1'b0;
        s_en = 1'b0; s_ext = 1'b1; s_trig = 1'b0;
        clear_stats();
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", 32'({p, n, busy, done, miss}), 32'd0);
        check("reset_outputs_small", 32'({s_p, s_n, s_busy, s_done, s_miss}), 32'd0);
        #10 rst = 1'b0;

        // External trigger, one 5-cycle TRIG pulse.
        en = 1'b1;
        repeat (3) tick();
        clear_stats();
        trig = 1'b1;
        te = cyc + 1;
        repeat (5) tick();
        trig = 1'b0;
        repeat (L + 20) tick();
        check("ext_p_rise_edge", 32'(qat(0)), 32'(te + 3));
        check("ext_burst_count", 32'(b_rises.size()), 32'd1);
        check("ext_busy_cycles", 32'(busy_cnt), 32'(L));
        check("ext_done_pulses", 32'(done_cnt), 32'd1);

        // Internal repetition timer.
        en = 1'b0; ext = 1'b0;
        repeat (3) tick();
        clear_stats();
        en = 1'b1;
        t0 = cyc;
        repeat (40100) tick();
        check("int_first_rise", 32'(qat(0)), 32'(t0 + R));
        check("int_second_rise", 32'(qat(1)), 32'(t0 + 2 * R));
        check("int_done_pulses", 32'(done_cnt), 32'd2);

        // Second TRIG edge 30 cycles into a burst.
        ext = 1'b1;
        repeat (3) tick();
        clear_stats();
        trig = 1'b1;
        repeat (3) tick();
        trig = 1'b0;
        repeat (30) tick();
        trig = 1'b1;
        repeat (3) tick();
        trig = 1'b0;
        repeat (L + 40) tick();
        check("miss_pulses", 32'(miss_cnt), 32'd1);
        check("miss_burst_count", 32'(b_rises.size()), 32'd1);
        check("miss_busy_cycles", 32'(busy_cnt), 32'(L));
        check("miss_done_pulses", 32'(done_cnt), 32'd1);

        // ENABLE dropped during the second N_ON, then a fresh burst.
        clear_stats();
        trig = 1'b1;
        te = cyc + 1;
        s = te + 3;
        repeat (3) tick();
        trig = 1'b0;
        while (cyc < s + 32) tick();
        en = 1'b0;
        tick();
        check("abort_legs_busy", 32'({p, n, busy}), 32'd0);
        repeat (10) tick();
        check("abort_no_done", 32'(done_cnt), 32'd0);
        check("abort_busy_cycles", 32'(busy_cnt), 32'd33);
        en = 1'b1;
        repeat (2) tick();
        clear_stats();
        trig = 1'b1;
        repeat (3) tick();
        trig = 1'b0;
        repeat (L + 10) tick();
        check("reenable_busy_cycles", 32'(busy_cnt), 32'(L));
        check("reenable_done", 32'(done_cnt), 32'd1);

        // Asynchronous reset in the middle of P_ON.
        trig = 1'b1;
        te = cyc + 1;
        s = te + 3;
        repeat (3) tick();
        trig = 1'b0;
        while (cyc < s + 2) tick();
        check("rst_pre_p_busy", 32'({p, n, busy}), 32'b101);
        #10 rst = 1'b1;
        #1 check("rst_async_clear", 32'({p, n, busy}), 32'd0);
        #5 rst = 1'b0;
        model_reset();
        last_busy = 1'b0;
        clear_stats();
        repeat (50) tick();
        check("rst_no_activity", 32'(busy_cnt + b_rises.size()), 32'd0);

        // Parameter override HALF_PERIOD=3, DEAD_TIME=1, NUM_PERIODS=1.
        s_en = 1'b1;
        for (int i = 0; i < 23; i++) begin
            s_trig = tbl[i].trig;
            @(posedge clk);
            #1;
            check($sformatf("small[%0d]", i), 32'({s_p, s_n, s_busy, s_done, s_miss}), 32'(tbl[i].exp));
        end
        s_trig = 1'b0;

        // Randomized external-mode traffic with occasional ENABLE and EXT_MODE glitches.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 39) == 0) trig = ~trig;
            en  = ($urandom_range(0, 199) != 0);
            ext = ($urandom_range(0, 49) != 0);
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/ema_burst_gen.md
Name: ema_burst_gen

Overview:
- Replaces the free-running divider that drives the EMA transducer pins with a controlled excitation source.
- Produces a burst of NUM_PERIODS complementary periods on EMA_PULSE_P / EMA_PULSE_N, with enforced dead time between the two legs.
- A burst starts from an internal repetition timer or from an external trigger.
- Sits directly upstream of the EMA H-bridge driver pins (68/69), clocked from the 20 MHz board oscillator on CLK_0.

Parameters:
- HALF_PERIOD, 10: CLK_0 cycles per half excitation period (10 = 1 MHz at 20 MHz).
- DEAD_TIME, 2: cycles with both legs low at each P/N transition. Must be ≥1 and < HALF_PERIOD.
- NUM_PERIODS, 4: full periods per burst. Must be ≥1.
- REP_PERIOD, 20000: internal repetition interval in cycles (1 kHz). Must be > 2*HALF_PERIOD*NUM_PERIODS.

Ports:
- CLK_0  in  1  20 MHz system clock, rising edge.
- RST  in  1  asynchronous, active-high reset.
- ENABLE  in  1  synchronous to CLK_0; gates all burst starts; low aborts a burst in progress.
- EXT_MODE  in  1  1 = start on TRIG edge; 0 = start on internal REP_PERIOD timer.
- TRIG  in  1  asynchronous external trigger; rising edge starts a burst.
- EMA_PULSE_P  out  1  positive leg drive, registered.
- EMA_PULSE_N  out  1  negative leg drive, registered.
- BUSY  out  1  high while a burst is in progress.
- BURST_DONE  out  1  one-cycle pulse when a burst completes normally.
- TRIG_MISS  out  1  one-cycle pulse when a start request arrives while BUSY.

Behaviour:
- Reset (async, RST=1):
  - All outputs are 0.
  - FSM is in IDLE; all counters are 0; synchronizer flops are 0.
- Hard invariant: EMA_PULSE_P and EMA_PULSE_N are never both 1, in any cycle, including reset release and abort.
- FSM states: IDLE, P_ON, DEAD_PN, N_ON, DEAD_NP.
  - IDLE → P_ON on a start request with ENABLE=1.
  - P_ON lasts HALF_PERIOD-DEAD_TIME cycles, P=1.
  - DEAD_PN lasts DEAD_TIME cycles, P=N=0.
  - N_ON lasts HALF_PERIOD-DEAD_TIME cycles, N=1.
  - DEAD_NP lasts DEAD_TIME cycles, P=N=0.
  - After DEAD_NP: if period count < NUM_PERIODS-1, increment the count and go to P_ON. Otherwise go to IDLE and pulse BURST_DONE on the cycle the FSM re-enters IDLE.
- Burst length is exactly 2*HALF_PERIOD*NUM_PERIODS cycles; defaults give 80.
- BUSY is 1 in every non-IDLE state.
- Outputs come from registered state decode, so they have no glitches.
- Internal start (EXT_MODE=0):
  - Repetition counter runs 0..REP_PERIOD-1 and wraps while ENABLE=1.
  - It is held at 0 while ENABLE=0.
  - The start request is asserted in the cycle the counter equals REP_PERIOD-1.
  - EMA_PULSE_P rises on the next edge. First burst P-rise is REP_PERIOD cycles after ENABLE rises.
- External start (EXT_MODE=1):
  - TRIG passes through a 2-flop synchronizer plus a rising-edge detect.
  - EMA_PULSE_P rises exactly 3 CLK_0 edges after the first edge sampling TRIG=1.
  - TRIG level held high does not retrigger.
  - The internal counter is held at 0 while EXT_MODE=1.
- Start request while BUSY: ignored (no queueing), TRIG_MISS pulses for 1 cycle. A start in the same cycle the FSM returns to IDLE is also a miss.
- ENABLE falling while BUSY:
  - On the next edge the FSM goes to IDLE and both legs go to 0.
  - BURST_DONE is not pulsed; the period counter is cleared.
- Reset mid-burst: both legs go low asynchronously.
- EXT_MODE change while BUSY: no effect on the current burst.
- Counter widths: $clog2 of the respective bound, minimum 1 bit. No arithmetic overflow is possible within the parameter constraints.
- Illegal parameter combinations are rejected at elaboration via a generate-time error.

Decomposition:
- Package ema_pkg:
  - FSM state enum.
  - Default timing constants (CLK_HZ=20_000_000, HALF_PERIOD, DEAD_TIME, NUM_PERIODS, REP_PERIOD).
  - Width helper function.
- Sub-module ema_trig_sync: 2-flop synchronizer + rising-edge detect, async reset, output a 1-cycle pulse. It is reusable for other asynchronous board inputs.

Test Plan:
- Defaults, EXT_MODE=1, ENABLE=1, one TRIG pulse of 5 cycles:
  - P rises 3 edges after the TRIG sample.
  - Pattern is P=1 ×8, 0/0 ×2, N=1 ×8, 0/0 ×2, repeated 4 times.
  - BUSY=1 for 80 cycles; BURST_DONE for 1 cycle after.
  - P&N never both 1 (assertion active for the whole run).
- EXT_MODE=0, ENABLE rises at t0:
  - P rises at t0+20000, then again at t0+40000.
  - Exactly 2 BURST_DONE pulses in 40100 cycles.
- Second TRIG edge 30 cycles into a burst: TRIG_MISS pulses once; the burst continues unchanged (80 cycles); no second burst follows.
- ENABLE dropped during the 2nd N_ON:
  - Next edge gives P=N=0, BUSY=0.
  - No BURST_DONE.
  - A new TRIG after re-enable produces a full 80-cycle burst.
- RST asserted mid P_ON, asynchronously between clock edges: P, N and BUSY go to 0 immediately. After release, no output activity until a new start request.
- Parameter override HALF_PERIOD=3, DEAD_TIME=1, NUM_PERIODS=1: one burst of P ×2, gap ×1, N ×2, gap ×1 (6 cycles), then BURST_DONE.
